// File: rtl/serial_tx_if.sv
// Word-in / line-out port bundle of serial_tx. The producer side uses master
// and the transmitter uses slave.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_line;
  logic              busy;

  modport master (output tx_data, output tx_valid,
                  input tx_ready, input tx_line, input busy);
  modport slave  (input tx_data, input tx_valid,
                  output tx_ready, output tx_line, output busy);
endinterface

// File: rtl/serial_tx.sv
// Async-serial transmitter: start bit, DATA_W data bits LSB first, stop bit,
// each bit held CLKS_PER_BIT clocks. The line is driven straight from a flop.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rstb,
  serial_tx_if.slave bus
);
  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              r_state, w_state_next;
  logic [TICK_W-1:0]   r_tick, w_tick_next;
  logic [BIT_W-1:0]    r_bit, w_bit_next;
  logic [DATA_W-1:0]   r_shreg, w_shreg_next;
  logic                r_line, w_line_next;
  logic                w_tick_last;
  logic [DATA_W-1:0]   w_shift;

  assign w_tick_last = (r_tick == TICK_LAST);
  assign w_shift     = r_shreg >> 1;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_line  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_tick  <= w_tick_next;
      r_bit   <= w_bit_next;
      r_shreg <= w_shreg_next;
      r_line  <= w_line_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tick_next  = r_tick;
    w_bit_next   = r_bit;
    w_shreg_next = r_shreg;
    w_line_next  = r_line;
    case (r_state)
      IDLE: begin
        w_line_next = 1'b1;
        if (bus.tx_valid) begin
          w_state_next = START;
          w_shreg_next = bus.tx_data;
          w_tick_next  = '0;
          w_bit_next   = '0;
          w_line_next  = 1'b0;
        end
      end
      START: begin
        if (w_tick_last) begin
          w_state_next = DATA;
          w_tick_next  = '0;
          w_line_next  = r_shreg[0];
        end else begin
          w_tick_next = r_tick + TICK_W'(1);
        end
      end
      DATA: begin
        if (w_tick_last) begin
          w_tick_next = '0;
          if (r_bit == BIT_LAST) begin
            w_state_next = STOP;
            w_bit_next   = '0;
            w_line_next  = 1'b1;
          end else begin
            // The next data bit is whatever lands in bit 0 after the shift.
            w_shreg_next = w_shift;
            w_line_next  = w_shift[0];
            w_bit_next   = r_bit + BIT_W'(1);
          end
        end else begin
          w_tick_next = r_tick + TICK_W'(1);
        end
      end
      STOP: begin
        if (w_tick_last) begin
          w_state_next = IDLE;
          w_tick_next  = '0;
        end else begin
          w_tick_next = r_tick + TICK_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_line_next  = 1'b1;
      end
    endcase
  end

  assign bus.tx_line  = r_line;
  assign bus.tx_ready = (r_state == IDLE);
  assign bus.busy     = (r_state != IDLE);
endmodule
